// File: rtl/mod_exp_pkg.sv
// Shared definitions for the sequential modular exponentiator:
// FSM state encoding, default widths and the worst-case latency helper.
package mod_exp_pkg;

  localparam int DEF_DATA_W = 24;
  localparam int DEF_EXP_W  = 24;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK_M = 3'd1,
    REDUCE  = 3'd2,
    SCAN    = 3'd3,
    MUL     = 3'd4,
    SQR     = 3'd5,
    FIN     = 3'd6
  } state_e;

  // Worst case: CHECK_M, REDUCE, one SCAN plus MUL and SQR per exponent bit,
  // final SCAN and FIN. Every multiplier call costs DATA_W+2 cycles in-state
  // (one issue cycle plus DATA_W+1 cycles until its done pulse).
  function automatic int latency_bound(input int data_w, input int exp_w);
    return 3 + (1 + 2 * exp_w) * (data_w + 2) + exp_w;
  endfunction

endpackage

// File: rtl/mod_exp_seq_if.sv
// Request/response bundle between a requester and the modular exponentiator.
interface mod_exp_seq_if
  import mod_exp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int EXP_W  = DEF_EXP_W
);

  logic              start;
  logic [DATA_W-1:0] base;
  logic [EXP_W-1:0]  exponent;
  logic [DATA_W-1:0] modulus;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              err;

  modport master (
    output start, base, exponent, modulus,
    input  busy, done, result, err
  );

  modport slave (
    input  start, base, exponent, modulus,
    output busy, done, result, err
  );

endinterface

// File: rtl/mod_mul.sv
// Interleaved shift-add modular multiplier: p = a*b mod m, one bit of b per
// cycle, MSB first. Requires a < m and m >= 2; b may be any value. The running
// remainder is two bits wider than the data so 2r + a never overflows before
// it is reduced.
module mod_mul
  import mod_exp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] m,
  output logic              done,
  output logic [DATA_W-1:0] p
);

  localparam int ACC_W = DATA_W + 2;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic              active_q, active_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] m_q, m_d;
  logic [ACC_W-1:0]  r_q, r_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] p_q, p_d;

  logic [ACC_W-1:0]  m_ext;
  logic [ACC_W-1:0]  r_dbl;
  logic [ACC_W-1:0]  r_sum;

  // One iteration: double, reduce, conditionally add a, reduce again.
  always_comb begin
    m_ext = {2'b00, m_q};
    r_dbl = {r_q[ACC_W-2:0], 1'b0};
    if (r_dbl >= m_ext) begin
      r_dbl = r_dbl - m_ext;
    end
    r_sum = r_dbl;
    if (b_q[DATA_W-1]) begin
      r_sum = r_dbl + {2'b00, a_q};
    end
    if (r_sum >= m_ext) begin
      r_sum = r_sum - m_ext;
    end
  end

  // Load operands on start, then walk b until its last bit has been consumed.
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    r_d      = r_q;
    done_d   = 1'b0;
    p_d      = p_q;
    if (start) begin
      active_d = 1'b1;
      cnt_d    = '0;
      a_d      = a;
      b_d      = b;
      m_d      = m;
      r_d      = '0;
    end else if (active_q) begin
      r_d   = r_sum;
      b_d   = {b_q[DATA_W-2:0], 1'b0};
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_BIT) begin
        active_d = 1'b0;
        done_d   = 1'b1;
        p_d      = r_sum[DATA_W-1:0];
      end
    end
  end

  // Multiplier state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      r_q      <= '0;
      done_q   <= 1'b0;
      p_q      <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      r_q      <= r_d;
      done_q   <= done_d;
      p_q      <= p_d;
    end
  end

  assign done = done_q;
  assign p    = p_q;

endmodule

// File: rtl/mod_exp_seq.sv
// Sequential right-to-left modular exponentiator: result = base^exponent mod
// modulus. A single mod_mul is time-shared for the initial base reduction, the
// accumulator multiply and the squaring step.
module mod_exp_seq
  import mod_exp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int EXP_W  = DEF_EXP_W
) (
  input  logic          clk,
  input  logic          rst,
  mod_exp_seq_if.slave  bus
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] mod_q, mod_d;
  logic [EXP_W-1:0]  e_q, e_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              issued_q, issued_d;
  logic              shifted_q, shifted_d;

  logic              mm_start;
  logic [DATA_W-1:0] mm_a;
  logic [DATA_W-1:0] mm_b;
  logic              mm_done;
  logic [DATA_W-1:0] mm_p;

  mod_mul #(
    .DATA_W (DATA_W)
  ) u_mod_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mm_start),
    .a     (mm_a),
    .b     (mm_b),
    .m     (mod_q),
    .done  (mm_done),
    .p     (mm_p)
  );

  // Next-state logic: each multiplier state issues one call, waits for its
  // done pulse, then commits the product. The exponent shifts exactly once
  // per bit, either in MUL or, if MUL was skipped, in SQR.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    mod_d     = mod_q;
    e_d       = e_q;
    x_d       = x_q;
    acc_d     = acc_q;
    result_d  = result_q;
    err_d     = err_q;
    issued_d  = issued_q;
    shifted_d = shifted_q;
    mm_start  = 1'b0;
    mm_a      = x_q;
    mm_b      = x_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          base_d  = bus.base;
          e_d     = bus.exponent;
          mod_d   = bus.modulus;
          err_d   = 1'b0;
          state_d = CHECK_M;
        end
      end

      CHECK_M: begin
        if (mod_q == '0) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = FIN;
        end else if (mod_q == DATA_W'(1)) begin
          result_d = '0;
          state_d  = FIN;
        end else begin
          state_d = REDUCE;
        end
      end

      REDUCE: begin
        mm_a = DATA_W'(1);
        mm_b = base_q;
        if (!issued_q) begin
          mm_start = 1'b1;
          issued_d = 1'b1;
        end else if (mm_done) begin
          x_d       = mm_p;
          acc_d     = DATA_W'(1);
          issued_d  = 1'b0;
          shifted_d = 1'b0;
          state_d   = SCAN;
        end
      end

      SCAN: begin
        shifted_d = 1'b0;
        if (e_q == '0) begin
          result_d = acc_q;
          state_d  = FIN;
        end else if (e_q[0]) begin
          state_d = MUL;
        end else begin
          state_d = SQR;
        end
      end

      MUL: begin
        mm_a = acc_q;
        mm_b = x_q;
        if (!issued_q) begin
          mm_start = 1'b1;
          issued_d = 1'b1;
        end else if (mm_done) begin
          acc_d     = mm_p;
          e_d       = e_q >> 1;
          shifted_d = 1'b1;
          issued_d  = 1'b0;
          if ((e_q >> 1) == '0) begin
            state_d = SCAN;
          end else begin
            state_d = SQR;
          end
        end
      end

      SQR: begin
        mm_a = x_q;
        mm_b = x_q;
        if (!issued_q) begin
          mm_start = 1'b1;
          issued_d = 1'b1;
        end else if (mm_done) begin
          x_d      = mm_p;
          issued_d = 1'b0;
          if (!shifted_q) begin
            e_d = e_q >> 1;
          end
          state_d = SCAN;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  // Exponentiator state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      mod_q     <= '0;
      e_q       <= '0;
      x_q       <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      issued_q  <= 1'b0;
      shifted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      mod_q     <= mod_d;
      e_q       <= e_d;
      x_q       <= x_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      issued_q  <= issued_d;
      shifted_q <= shifted_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_mod_exp_seq.sv
// Scoreboard bench for mod_exp_seq: the driver pushes reference results when a
// request is issued, the monitor pops and compares on every done pulse.
module tb_mod_exp_seq;
  import mod_exp_pkg::*;

  localparam int DATA_W     = 24;
  localparam int EXP_W      = 24;
  localparam int BOUND      = latency_bound(DATA_W, EXP_W);
  localparam int WAIT_LIMIT = BOUND + 50;

  typedef struct {
    logic [DATA_W-1:0] res;
    logic              err;
  } expect_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  expect_t           exp_q[$];
  expect_t           got_exp;
  int                n_vectors = 0;
  int                n_miscompares = 0;
  int                cyc = 0;
  logic              prev_done = 1'b0;
  logic [DATA_W-1:0] last_want = '0;

  mod_exp_seq_if #(.DATA_W(DATA_W), .EXP_W(EXP_W)) bus ();

  mod_exp_seq #(
    .DATA_W (DATA_W),
    .EXP_W  (EXP_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Left-to-right square-and-multiply on 64-bit integers.
  function automatic logic [DATA_W-1:0] ref_modexp(input logic [DATA_W-1:0] b,
                                                   input logic [EXP_W-1:0] e,
                                                   input logic [DATA_W-1:0] m);
    longint unsigned r, bb, mm;
    if (m < 2) return '0;
    mm = 64'(m);
    bb = 64'(b) % mm;
    r  = 1;
    for (int i = EXP_W - 1; i >= 0; i--) begin
      r = (r * r) % mm;
      if (e[i]) r = (r * bb) % mm;
    end
    return DATA_W'(r);
  endfunction

  // Monitor: checks handshake shape and compares each result with the scoreboard.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      cyc       = 0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) begin
        checkOutput("busy_after_done", 64'(bus.busy), 64'd0);
        checkOutput("done_single_pulse", 64'(bus.done), 64'd0);
      end
      if (bus.busy) cyc++;
      if (bus.busy && !bus.done && cyc == 1) begin
        checkOutput("err_cleared_on_accept", 64'(bus.err), 64'd0);
      end
      if (bus.done) begin
        checkOutput("busy_with_done", 64'(bus.busy), 64'd1);
        if (exp_q.size() == 0) begin
          n_vectors++;
          n_miscompares++;
          $display("[TB] FAIL unexpected_done: got result %0d, expected no done", bus.result);
        end else begin
          got_exp = exp_q.pop_front();
          checkOutput("result", 64'(bus.result), 64'(got_exp.res));
          checkOutput("err", 64'(bus.err), 64'(got_exp.err));
          n_vectors++;
          if (cyc > BOUND) begin
            n_miscompares++;
            $display("[TB] FAIL latency: got %0d cycles, required <= %0d", cyc, BOUND);
          end
        end
        cyc = 0;
      end
      prev_done = bus.done;
    end
  end

  task automatic waitIdle();
    int n = 0;
    while (bus.busy !== 1'b0) begin
      @(negedge clk);
      n++;
      if (n > WAIT_LIMIT) begin
        n_vectors++;
        n_miscompares++;
        $display("[TB] FAIL idle_timeout: got busy for %0d cycles, required <= %0d", n, WAIT_LIMIT);
        return;
      end
    end
  endtask

  task automatic applyStimulus(input logic [DATA_W-1:0] b, input logic [EXP_W-1:0] e,
                               input logic [DATA_W-1:0] m, input logic [DATA_W-1:0] want_res,
                               input logic want_err);
    waitIdle();
    bus.start    = 1'b1;
    bus.base     = b;
    bus.exponent = e;
    bus.modulus  = m;
    exp_q.push_back('{res: want_res, err: want_err});
    last_want = want_res;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.base     = DATA_W'($urandom);
    bus.exponent = EXP_W'($urandom);
    bus.modulus  = DATA_W'($urandom);
  endtask

  task automatic applyModel(input logic [DATA_W-1:0] b, input logic [EXP_W-1:0] e,
                            input logic [DATA_W-1:0] m);
    applyStimulus(b, e, m, ref_modexp(b, e, m), (m == '0));
  endtask

  // Watchdog so a stuck design still ends the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    logic [DATA_W-1:0] rb, rm;
    logic [EXP_W-1:0]  re;
    int                ew;
    int                n;

    bus.start    = 1'b0;
    bus.base     = '0;
    bus.exponent = '0;
    bus.modulus  = '0;
    rst          = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    checkOutput("reset_done", 64'(bus.done), 64'd0);
    checkOutput("reset_err", 64'(bus.err), 64'd0);
    checkOutput("reset_result", 64'(bus.result), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(24'd4, 24'd13, 24'd497, 24'd445, 1'b0);
    applyStimulus(24'd65, 24'd17, 24'd3233, 24'd2790, 1'b0);
    applyStimulus(24'd2790, 24'd2753, 24'd3233, 24'd65, 1'b0);
    applyStimulus(24'd100, 24'd1, 24'd7, 24'd2, 1'b0);
    applyStimulus(24'd7, 24'd0, 24'd13, 24'd1, 1'b0);
    applyStimulus(24'd13, 24'd5, 24'd13, 24'd0, 1'b0);
    applyStimulus(24'd12345, 24'd678, 24'd1, 24'd0, 1'b0);
    applyStimulus(24'd999, 24'd12345, 24'd0, 24'd0, 1'b1);
    applyStimulus(24'd3, 24'd4, 24'd10, 24'd1, 1'b0);
    applyModel(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFD);

    // A start pulsed while busy must be dropped and leave result alone.
    applyModel(24'd123456, 24'd99, 24'd777777);
    repeat (5) @(negedge clk);
    bus.start    = 1'b1;
    bus.base     = 24'd5;
    bus.exponent = 24'd3;
    bus.modulus  = 24'd11;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("result_held_while_busy", 64'(bus.result), 64'(ref_modexp(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFD)));

    // Reset lands inside the first squaring of this operation.
    applyModel(24'd5, 24'd2, 24'd1000003);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    checkOutput("abort_busy", 64'(bus.busy), 64'd0);
    checkOutput("abort_done", 64'(bus.done), 64'd0);
    checkOutput("abort_result", 64'(bus.result), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyModel(24'd5, 24'd2, 24'd1000003);

    // Randomised operands with varying exponent lengths.
    for (int i = 0; i < 14; i++) begin
      rb = DATA_W'($urandom);
      ew = $urandom_range(0, EXP_W);
      re = (ew == 0) ? '0 : EXP_W'($urandom) & EXP_W'((64'd1 << ew) - 1);
      case ($urandom_range(0, 5))
        0:       rm = DATA_W'($urandom_range(0, 3));
        1:       rm = DATA_W'($urandom_range(2, 300));
        default: rm = DATA_W'($urandom);
      endcase
      applyModel(rb, re, rm);
    end

    // Drain outstanding results.
    n = 0;
    while ((exp_q.size() != 0 || bus.busy !== 1'b0) && n <= WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n > WAIT_LIMIT) begin
      n_vectors++;
      n_miscompares++;
      $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
